// File: rtl/sd_pkg.sv
// sd_pkg: shared definitions for the SD-card SPI receive and send paths.
//   - rx_type_e   : decoded receive request type (R1, R3/R7, data block)
//   - rx_state_e  : receiver FSM states
//   - StartToken, BlockBits, Crc16Poly, R1Bits, R7Bits : protocol constants
//   - crc16_step  : one serial step of the CCITT CRC16 LFSR
package sd_pkg;

    typedef enum logic [1:0] {
        RX_R1   = 2'd0,
        RX_R3R7 = 2'd1,
        RX_DATA = 2'd2
    } rx_type_e;

    typedef enum logic [2:0] {
        ST_IDLE          = 3'd0,
        ST_WAIT_TOKEN    = 3'd1,
        ST_READ_RESPONSE = 3'd2,
        ST_READ_DATA     = 3'd3,
        ST_READ_CRC      = 3'd4,
        ST_FINISH        = 3'd5
    } rx_state_e;

    localparam logic [7:0]  StartToken = 8'hFE;
    localparam int unsigned BlockBits  = 4096;
    localparam logic [15:0] Crc16Poly  = 16'h1021;
    localparam int unsigned R1Bits     = 8;
    localparam int unsigned R7Bits     = 40;

    // Shift one bit (MSB-first stream) through the CCITT CRC16 register.
    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic bit_in);
        logic fb;
        fb = crc[15] ^ bit_in;
        return {crc[14:0], 1'b0} ^ (fb ? Crc16Poly : 16'h0000);
    endfunction

endpackage

// File: rtl/sd_crc16.sv
// sd_crc16: serial CCITT CRC16 (x^16+x^12+x^5+1), init 0.
//   clock, reset : clock and asynchronous active-high reset
//   clear        : synchronous clear to 0 (takes priority over enable)
//   enable       : advance the LFSR by bit_in this cycle
//   bit_in       : serial input bit, MSB first
//   crc          : registered CRC value
module sd_crc16
(
    input  logic        clock,
    input  logic        reset,
    input  logic        clear,
    input  logic        enable,
    input  logic        bit_in,
    output logic [15:0] crc
);
    import sd_pkg::*;

    logic [15:0] crc_r;

    // CRC register: clear on request, otherwise step once per enabled bit.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            crc_r <= 16'h0000;
        end else if (clear) begin
            crc_r <= 16'h0000;
        end else if (enable) begin
            crc_r <= crc16_step(crc_r, bit_in);
        end else begin
            crc_r <= crc_r;
        end
    end

    assign crc = crc_r;

endmodule

// File: rtl/sd_receiver.sv
// sd_receiver: SPI MISO receive path of the SD controller.
// Captures R1 / R3/R7 responses and 512-byte data blocks (one bit per clock),
// detects start/error tokens, checks the block CRC16 and enforces timeouts.
//   clock, reset        : bit clock, asynchronous active-high reset
//   receive_type, valid : request (0 R1, 1 R3/R7, 2 data, 3 as R1); accepted on ready & valid
//   ready               : high only while idle
//   miso                : serial data from the card, MSB first
//   done                : one-cycle pulse, result outputs valid
//   response, data      : captured response / block (first block bit in data[4095])
//   crc_error, token_error, timeout : result flags
module sd_receiver
#(
    parameter int unsigned ResponseTimeout = 8,
    parameter int unsigned DataTimeout     = 65535
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [1:0]    receive_type,
    input  logic          valid,
    output logic          ready,
    input  logic          miso,
    output logic          done,
    output logic [39:0]   response,
    output logic [4095:0] data,
    output logic          crc_error,
    output logic          token_error,
    output logic          timeout
);
    import sd_pkg::*;

    localparam logic [15:0] RespLimit    = 16'(ResponseTimeout);
    localparam logic [15:0] DataLimit    = 16'(DataTimeout);
    localparam logic [12:0] ByteReload   = 13'(R1Bits - 1);
    localparam logic [12:0] R7TailReload = 13'(R7Bits - R1Bits - 1);
    localparam logic [12:0] BlockReload  = 13'(BlockBits - 1);
    localparam logic [12:0] CrcReload    = 13'd15;

    rx_state_e            state_r, state_next_s;
    rx_type_e             type_r;
    logic [12:0]          bit_cnt_r;
    logic [15:0]          tmo_cnt_r;
    logic [6:0]           shift_r;
    logic [14:0]          crc_rx_r;
    logic                 ready_r, done_r, crc_error_r, token_error_r, timeout_r;
    logic [39:0]          response_r;
    logic [BlockBits-1:0] data_r;
    logic [15:0]          crc_s, tmo_limit_s;
    logic [16:0]          tmo_inc_s;
    logic [7:0]           byte_s;
    logic                 accept_s, last_bit_s, tmo_hit_s;
    logic                 resp_hit_s, tok_start_s, tok_err_s, tmo_fire_s, tmo_step_s;

    // Byte including the bit being sampled this edge; only meaningful at a byte boundary.
    assign byte_s      = {shift_r, miso};
    assign accept_s    = ready_r & valid;
    assign last_bit_s  = (bit_cnt_r == 13'd0);
    assign tmo_limit_s = (type_r == RX_DATA) ? DataLimit : RespLimit;
    assign tmo_inc_s   = {1'b0, tmo_cnt_r} + 17'd1;
    // The byte being rejected now would be the limit-th one.
    assign tmo_hit_s   = (tmo_inc_s >= {1'b0, tmo_limit_s});

    sd_crc16 u_crc16 (
        .clock  (clock),
        .reset  (reset),
        .clear  (tok_start_s),
        .enable (state_r == ST_READ_DATA),
        .bit_in (miso),
        .crc    (crc_s)
    );

    // FSM state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic and the per-byte decision strobes used by the datapath.
    always_comb begin
        state_next_s = state_r;
        resp_hit_s   = 1'b0;
        tok_start_s  = 1'b0;
        tok_err_s    = 1'b0;
        tmo_fire_s   = 1'b0;
        tmo_step_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_next_s = ST_WAIT_TOKEN;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_WAIT_TOKEN: begin
                if (!last_bit_s) begin
                    state_next_s = ST_WAIT_TOKEN;
                end else if (type_r == RX_DATA) begin
                    if (byte_s == StartToken) begin
                        tok_start_s  = 1'b1;
                        state_next_s = ST_READ_DATA;
                    end else if (byte_s[7:4] == 4'h0) begin
                        tok_err_s    = 1'b1;
                        state_next_s = ST_FINISH;
                    end else if (tmo_hit_s) begin
                        tmo_fire_s   = 1'b1;
                        state_next_s = ST_FINISH;
                    end else begin
                        tmo_step_s   = 1'b1;
                        state_next_s = ST_WAIT_TOKEN;
                    end
                end else begin
                    if (!byte_s[7]) begin
                        resp_hit_s = 1'b1;
                        if (type_r == RX_R1) begin
                            state_next_s = ST_FINISH;
                        end else begin
                            state_next_s = ST_READ_RESPONSE;
                        end
                    end else if (tmo_hit_s) begin
                        tmo_fire_s   = 1'b1;
                        state_next_s = ST_FINISH;
                    end else begin
                        tmo_step_s   = 1'b1;
                        state_next_s = ST_WAIT_TOKEN;
                    end
                end
            end
            ST_READ_RESPONSE: begin
                if (last_bit_s) begin
                    state_next_s = ST_FINISH;
                end else begin
                    state_next_s = ST_READ_RESPONSE;
                end
            end
            ST_READ_DATA: begin
                if (last_bit_s) begin
                    state_next_s = ST_READ_CRC;
                end else begin
                    state_next_s = ST_READ_DATA;
                end
            end
            ST_READ_CRC: begin
                if (last_bit_s) begin
                    state_next_s = ST_FINISH;
                end else begin
                    state_next_s = ST_READ_CRC;
                end
            end
            ST_FINISH: state_next_s = ST_IDLE;
            default:   state_next_s = ST_IDLE;
        endcase
    end

    // Datapath: counters, shift registers and registered result outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            type_r        <= RX_R1;
            bit_cnt_r     <= 13'd0;
            tmo_cnt_r     <= 16'd0;
            shift_r       <= 7'd0;
            crc_rx_r      <= 15'd0;
            ready_r       <= 1'b1;
            done_r        <= 1'b0;
            response_r    <= 40'd0;
            data_r        <= '0;
            crc_error_r   <= 1'b0;
            token_error_r <= 1'b0;
            timeout_r     <= 1'b0;
        end else begin
            ready_r <= (state_next_s == ST_IDLE);
            done_r  <= (state_next_s == ST_FINISH);
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        case (receive_type)
                            2'd1:    type_r <= RX_R3R7;
                            2'd2:    type_r <= RX_DATA;
                            default: type_r <= RX_R1;
                        endcase
                        bit_cnt_r     <= ByteReload;
                        tmo_cnt_r     <= 16'd0;
                        shift_r       <= 7'd0;
                        response_r    <= 40'd0;
                        data_r        <= '0;
                        crc_error_r   <= 1'b0;
                        token_error_r <= 1'b0;
                        timeout_r     <= 1'b0;
                    end
                end
                ST_WAIT_TOKEN: begin
                    shift_r <= byte_s[6:0];
                    if (!last_bit_s) begin
                        bit_cnt_r <= bit_cnt_r - 13'd1;
                    end else if (resp_hit_s) begin
                        // R1 byte lands in [7:0]; for R3/R7 the tail shifts it up to [39:32].
                        response_r[7:0] <= byte_s;
                        bit_cnt_r       <= R7TailReload;
                    end else if (tok_start_s) begin
                        bit_cnt_r <= BlockReload;
                    end else if (tok_err_s) begin
                        token_error_r   <= 1'b1;
                        response_r[7:0] <= byte_s;
                    end else if (tmo_fire_s) begin
                        timeout_r <= 1'b1;
                    end else begin
                        bit_cnt_r <= ByteReload;
                        if (tmo_cnt_r != 16'hFFFF) begin
                            tmo_cnt_r <= tmo_inc_s[15:0];
                        end
                    end
                end
                ST_READ_RESPONSE: begin
                    response_r <= {response_r[38:0], miso};
                    bit_cnt_r  <= bit_cnt_r - 13'd1;
                end
                ST_READ_DATA: begin
                    data_r <= {data_r[BlockBits-2:0], miso};
                    if (last_bit_s) begin
                        bit_cnt_r <= CrcReload;
                    end else begin
                        bit_cnt_r <= bit_cnt_r - 13'd1;
                    end
                end
                ST_READ_CRC: begin
                    crc_rx_r  <= {crc_rx_r[13:0], miso};
                    bit_cnt_r <= bit_cnt_r - 13'd1;
                    if (last_bit_s) begin
                        crc_error_r <= ({crc_rx_r, miso} != crc_s);
                    end
                end
                default: begin
                    bit_cnt_r <= bit_cnt_r;
                end
            endcase
        end
    end

    assign ready       = ready_r;
    assign done        = done_r;
    assign response    = response_r;
    assign data        = data_r;
    assign crc_error   = crc_error_r;
    assign token_error = token_error_r;
    assign timeout     = timeout_r;

endmodule

// File: tb/tb_sd_receiver.sv
// tb_sd_receiver: directed and randomized self-checking bench for sd_receiver.
// Expected results come from a byte-level reference model of the receive rules.
module tb_sd_receiver;

    localparam int RESP_TMO = 8;
    localparam int DATA_TMO = 20;

    logic          clock, reset, valid, ready, miso, done;
    logic [1:0]    receive_type;
    logic [39:0]   response;
    logic [4095:0] data;
    logic          crc_error, token_error, timeout;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0]    tx_bytes[$];
    int            exp_n_g;
    logic [39:0]   exp_resp_g;
    logic [4095:0] exp_data_g;
    logic          exp_crc_g, exp_tok_g, exp_tmo_g;

    sd_receiver #(.ResponseTimeout(RESP_TMO), .DataTimeout(DATA_TMO)) dut (
        .clock(clock), .reset(reset), .receive_type(receive_type), .valid(valid),
        .ready(ready), .miso(miso), .done(done), .response(response), .data(data),
        .crc_error(crc_error), .token_error(token_error), .timeout(timeout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic [7:0] byte_at(input int idx);
        if (idx < tx_bytes.size()) return tx_bytes[idx];
        return 8'hFF;
    endfunction

    function automatic logic bit_at(input int idx);
        logic [7:0] b;
        b = byte_at(idx / 8);
        return b[7 - (idx % 8)];
    endfunction

    function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c;
        for (int k = 7; k >= 0; k--) begin
            if (r[15] ^ d[k]) r = (r << 1) ^ 16'h1021;
            else              r = r << 1;
        end
        return r;
    endfunction

    // Reference model: walk the byte stream with the protocol rules.
    task automatic model_tx(input int typ);
        int t, i, cnt;
        bit fin;
        logic [7:0] b;
        logic [15:0] c, rx;
        t = (typ == 3) ? 0 : typ;
        exp_resp_g = '0; exp_data_g = '0;
        exp_crc_g = 1'b0; exp_tok_g = 1'b0; exp_tmo_g = 1'b0;
        exp_n_g = 0; i = 0; cnt = 0; fin = 1'b0;
        while (!fin) begin
            b = byte_at(i);
            i++;
            if (t == 2) begin
                if (b == 8'hFE) begin
                    c = 16'h0000;
                    for (int j = 0; j < 512; j++) begin
                        exp_data_g = {exp_data_g[4087:0], byte_at(i + j)};
                        c = crc_byte(c, byte_at(i + j));
                    end
                    rx = {byte_at(i + 512), byte_at(i + 513)};
                    exp_crc_g = (rx != c);
                    exp_n_g = 8 * i + 4096 + 16;
                    fin = 1'b1;
                end else if (b[7:4] == 4'h0) begin
                    exp_tok_g = 1'b1;
                    exp_resp_g = {32'h0, b};
                    exp_n_g = 8 * i;
                    fin = 1'b1;
                end else begin
                    cnt++;
                end
            end else begin
                if (!b[7]) begin
                    if (t == 0) begin
                        exp_resp_g = {32'h0, b};
                        exp_n_g = 8 * i;
                    end else begin
                        exp_resp_g = {b, byte_at(i), byte_at(i + 1), byte_at(i + 2), byte_at(i + 3)};
                        exp_n_g = 8 * i + 32;
                    end
                    fin = 1'b1;
                end else begin
                    cnt++;
                end
            end
            if (!fin && cnt == ((t == 2) ? DATA_TMO : RESP_TMO)) begin
                exp_tmo_g = 1'b1;
                exp_n_g = 8 * i;
                fin = 1'b1;
            end
        end
    endtask

    // Issue one request, stream tx_bytes on MISO, and check against the expectations.
    task automatic run_tx(input string name, input logic [1:0] typ, input int exp_n,
                          input logic [39:0] exp_resp, input logic exp_crc,
                          input logic exp_tok, input logic exp_tmo);
        int cycles, wi;
        bit seen;
        cycles = 0;
        while (!ready && cycles < 100) begin
            @(posedge clock); #1;
            cycles++;
        end
        @(negedge clock);
        valid = 1'b1; receive_type = typ; miso = 1'b1;
        @(posedge clock); #1;
        check_eq({name, "_busy"}, 64'(ready), 64'd0);
        seen = 1'b0; cycles = 0;
        while (!seen && cycles < exp_n + 64) begin
            @(negedge clock);
            miso = bit_at(cycles);
            valid = 1'($urandom_range(0, 1));
            receive_type = 2'($urandom_range(0, 3));
            @(posedge clock); #1;
            cycles++;
            if (done) seen = 1'b1;
        end
        @(negedge clock);
        valid = 1'b0; miso = 1'b1;
        check_eq({name, "_latency"}, 64'(cycles), 64'(exp_n));
        check_eq({name, "_response"}, 64'(response), 64'(exp_resp));
        check_eq({name, "_crc_error"}, 64'(crc_error), 64'(exp_crc));
        check_eq({name, "_token_error"}, 64'(token_error), 64'(exp_tok));
        check_eq({name, "_timeout"}, 64'(timeout), 64'(exp_tmo));
        wi = 0;
        for (int w = 63; w >= 0; w--) begin
            if (data[w*64 +: 64] !== exp_data_g[w*64 +: 64]) wi = w;
        end
        check_eq($sformatf("%s_data_w%0d", name, wi), data[wi*64 +: 64], exp_data_g[wi*64 +: 64]);
        @(posedge clock); #1;
        check_eq({name, "_done_pulse"}, 64'(done), 64'd0);
        check_eq({name, "_ready_after"}, 64'(ready), 64'd1);
        check_eq({name, "_hold"}, 64'(response), 64'(exp_resp));
        if (!seen) begin
            @(negedge clock); reset = 1'b1;
            @(negedge clock); reset = 1'b0;
        end
    endtask

    task automatic push_block(input logic [7:0] fill, input logic [15:0] crc);
        tx_bytes.push_back(8'hFE);
        for (int j = 0; j < 512; j++) tx_bytes.push_back(fill);
        tx_bytes.push_back(crc[15:8]);
        tx_bytes.push_back(crc[7:0]);
    endtask

    initial begin
        int typ, pre, kind;
        logic [7:0] b;
        logic [15:0] c;
        reset = 1'b1; valid = 1'b0; receive_type = 2'd0; miso = 1'b1;
        #1;
        check_eq("reset_ready", 64'(ready), 64'd1);
        check_eq("reset_done", 64'(done), 64'd0);
        check_eq("reset_response", 64'(response), 64'd0);
        check_eq("reset_flags", 64'({crc_error, token_error, timeout}), 64'd0);
        check_eq("reset_data", data[4095:4032], 64'd0);
        repeat (3) @(posedge clock);
        @(negedge clock); reset = 1'b0;

        // Directed cases with hand-derived expectations.
        exp_data_g = '0;
        tx_bytes = '{8'hFF, 8'hFF, 8'h01};
        run_tx("r1", 2'd0, 24, 40'h01, 1'b0, 1'b0, 1'b0);
        tx_bytes = '{8'hFF, 8'h01, 8'h00, 8'h00, 8'h01, 8'hAA};
        run_tx("r7", 2'd1, 48, 40'h01000001AA, 1'b0, 1'b0, 1'b0);
        exp_data_g = '1;
        tx_bytes = '{8'hFF};
        push_block(8'hFF, 16'h7FA1);
        run_tx("blk_ok", 2'd2, 4128, 40'h0, 1'b0, 1'b0, 1'b0);
        tx_bytes = '{8'hFF};
        push_block(8'hFF, 16'h7FA0);
        run_tx("blk_bad", 2'd2, 4128, 40'h0, 1'b1, 1'b0, 1'b0);
        exp_data_g = '0;
        tx_bytes = '{8'hFF, 8'h05};
        run_tx("tok_err", 2'd2, 16, 40'h05, 1'b0, 1'b1, 1'b0);
        tx_bytes.delete();
        run_tx("r1_tmo", 2'd0, 64, 40'h0, 1'b0, 1'b0, 1'b1);
        run_tx("data_tmo", 2'd2, 8 * DATA_TMO, 40'h0, 1'b0, 1'b0, 1'b1);

        // Reset in the middle of a data block.
        tx_bytes = '{8'hFE};
        @(negedge clock); valid = 1'b1; receive_type = 2'd2;
        @(posedge clock); #1; valid = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clock); miso = bit_at(i);
            @(posedge clock);
        end
        @(negedge clock); reset = 1'b1; miso = 1'b1;
        @(posedge clock); #1;
        check_eq("mid_reset_ready", 64'(ready), 64'd1);
        check_eq("mid_reset_done", 64'(done), 64'd0);
        check_eq("mid_reset_data", data[4095:4032], 64'd0);
        check_eq("mid_reset_out", 64'({response, crc_error, token_error, timeout}), 64'd0);
        @(negedge clock); reset = 1'b0;
        tx_bytes = '{8'hFF, 8'h05};
        run_tx("r1_after_rst", 2'd3, 16, 40'h05, 1'b0, 1'b0, 1'b0);

        // Randomized transactions checked against the reference model.
        for (int n = 0; n < 24; n++) begin
            typ = int'($urandom_range(0, 3));
            tx_bytes.delete();
            if (typ != 2) begin
                pre = int'($urandom_range(0, RESP_TMO + 1));
                repeat (pre) tx_bytes.push_back(8'h80 | 8'($urandom_range(0, 127)));
                tx_bytes.push_back(8'($urandom_range(0, 127)));
                repeat (4) tx_bytes.push_back(8'($urandom_range(0, 255)));
            end else begin
                pre = int'($urandom_range(0, DATA_TMO + 1));
                repeat (pre) tx_bytes.push_back(8'($urandom_range(16, 253)));
                kind = int'($urandom_range(0, 3));
                if (kind == 0) begin
                    tx_bytes.push_back(8'($urandom_range(0, 15)));
                end else begin
                    tx_bytes.push_back(8'hFE);
                    c = 16'h0000;
                    for (int j = 0; j < 512; j++) begin
                        b = 8'($urandom_range(0, 255));
                        tx_bytes.push_back(b);
                        c = crc_byte(c, b);
                    end
                    if (kind == 1) c = c ^ 16'($urandom_range(1, 65535));
                    tx_bytes.push_back(c[15:8]);
                    tx_bytes.push_back(c[7:0]);
                end
            end
            model_tx(typ);
            run_tx($sformatf("rnd%0d", n), 2'(typ), exp_n_g, exp_resp_g, exp_crc_g, exp_tok_g, exp_tmo_g);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
